// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register; window registered 1 cycle after the accept; pix_ready drops while an unaccepted window is held.
// Define CONV_WINGEN_ZPAD_EN for 'same' zero padding (IMG_W*IMG_H windows, IMG_W+1 internal flush pixels per frame).
module conv_window_gen #(
   parameter int TOTAL_BITS = 16,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [TOTAL_BITS-1:0]   pix_in,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   output logic [9*TOTAL_BITS-1:0] window_out,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic                    frame_done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

   state_t                  state, state_d;
   logic [CW-1:0]           col, col_d;
   logic [RW-1:0]           row, row_d;
   logic [TOTAL_BITS-1:0]   lb0   [IMG_W];
   logic [TOTAL_BITS-1:0]   lb1   [IMG_W];
   logic [TOTAL_BITS-1:0]   win   [9];
   logic [TOTAL_BITS-1:0]   win_d [9];
   logic [9*TOTAL_BITS-1:0] wout_d;
   logic                    out_last;
   logic                    out_free;
   logic                    step;
   logic                    emit;
   logic                    is_last;
   logic [TOTAL_BITS-1:0]   pix_eff;

   assign out_free = !win_valid || win_ready;

`ifdef CONV_WINGEN_ZPAD_EN
   localparam int FW = $clog2(IMG_W + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

   logic [FW-1:0] flush_cnt, flush_d;
   logic [CW-1:0] ccol;
   logic [RW-1:0] crow;

   // Flush pixels are injected internally whenever the output register is free.
   assign pix_ready = out_free && (state != S_FLUSH);
   assign step      = (state == S_FLUSH) ? out_free : (pix_valid && pix_ready);
   assign pix_eff   = (state == S_FLUSH) ? '0 : pix_in;
   assign emit      = step && (state != S_FILL);
   assign is_last   = (crow == ROW_LAST) && (ccol == COL_LAST);
`else
   assign pix_ready = out_free;
   assign step      = pix_valid && pix_ready;
   assign pix_eff   = pix_in;
   assign emit      = step && (state == S_RUN);
   assign is_last   = (row == ROW_LAST) && (col == COL_LAST);
`endif

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_d[3*r]   = win[3*r+1];
         win_d[3*r+1] = win[3*r+2];
      end
      win_d[2] = lb1[col];
      win_d[5] = lb0[col];
      win_d[8] = pix_eff;
   end

   always_comb begin
      wout_d = '0;
      for (int i = 0; i < 9; i++) begin
         wout_d[(8-i)*TOTAL_BITS +: TOTAL_BITS] = win_d[i];
`ifdef CONV_WINGEN_ZPAD_EN
         // Taps outside the image around the centre (crow, ccol) read as zero.
         if ((i < 3 && crow == '0) || (i > 5 && crow == ROW_LAST) ||
             (i % 3 == 0 && ccol == '0) || (i % 3 == 2 && ccol == COL_LAST))
            wout_d[(8-i)*TOTAL_BITS +: TOTAL_BITS] = '0;
`endif
      end
   end

   always_comb begin
      state_d = state;
      col_d   = col;
      row_d   = row;
`ifdef CONV_WINGEN_ZPAD_EN
      flush_d = flush_cnt;
`endif
      if (step) begin
         if (col == COL_LAST) begin
            col_d = '0;
            row_d = (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col_d = col + 1'b1;
         end
`ifdef CONV_WINGEN_ZPAD_EN
         case (state)
            S_FILL:  if (row == RW'(1) && col == '0) state_d = S_RUN;
            S_RUN:   if (row == ROW_LAST && col == COL_LAST) begin
                        state_d = S_FLUSH;
                        flush_d = '0;
                     end
            S_FLUSH: begin
                        flush_d = flush_cnt + 1'b1;
                        if (flush_cnt == FLUSH_LAST) begin
                           state_d = S_FILL;
                           col_d   = '0;
                           row_d   = '0;
                        end
                     end
            default: state_d = S_FILL;
         endcase
`else
         case (state)
            S_FILL:  if (row >= RW'(2) && col == CW'(1)) state_d = S_RUN;
            S_RUN:   if (col == COL_LAST) state_d = S_FILL;
            default: state_d = S_FILL;
         endcase
`endif
      end
   end

   // Line buffers and the window shift register need no reset.
   always_ff @(posedge clk) begin
      if (step) begin
         lb1[col] <= lb0[col];
         lb0[col] <= pix_eff;
         win      <= win_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FILL;
         col        <= '0;
         row        <= '0;
         window_out <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_last   <= 1'b0;
`ifdef CONV_WINGEN_ZPAD_EN
         flush_cnt  <= '0;
         ccol       <= '0;
         crow       <= '0;
`endif
      end else begin
         state      <= state_d;
         col        <= col_d;
         row        <= row_d;
         frame_done <= win_valid && win_ready && out_last;
         if (emit) begin
            window_out <= wout_d;
            win_valid  <= 1'b1;
            out_last   <= is_last;
         end else if (win_ready) begin
            win_valid  <= 1'b0;
         end
`ifdef CONV_WINGEN_ZPAD_EN
         flush_cnt <= flush_d;
         if (emit) begin
            if (ccol == COL_LAST) begin
               ccol <= '0;
               crow <= (crow == ROW_LAST) ? '0 : crow + 1'b1;
            end else begin
               ccol <= ccol + 1'b1;
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 frame with pixel value = raster index (+ frame offset).
module tb_conv_window_gen;
   localparam int TB = 16;
   localparam int W  = 4;
   localparam int H  = 4;
`ifdef CONV_WINGEN_ZPAD_EN
   localparam int NWIN = 16;
`else
   localparam int NWIN = 4;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [TB-1:0]   pix_in;
   logic            pix_valid;
   logic            pix_ready;
   logic [9*TB-1:0] window_out;
   logic            win_valid;
   logic            win_ready;
   logic            frame_done;

   conv_window_gen #(.TOTAL_BITS(TB), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .window_out(window_out), .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int r;
      int c;
      int taps[9];
   } vec_t;

   vec_t            tbl[4];
   int              checks = 0;
   int              failures = 0;
   logic [9*TB-1:0] got[$];
   int              fd_cnt = 0;
   bit              acc_prev = 1'b0;

   task automatic check(input string name, input logic [9*TB-1:0] act, input logic [9*TB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [9*TB-1:0] pack9(input int t[9], input int base);
      logic [9*TB-1:0] v;
      v = '0;
      for (int i = 0; i < 9; i++) v[(8-i)*TB +: TB] = TB'(t[i] + base);
      return v;
   endfunction

   // Windows are captured when handed over; frame_done must follow the frame's last handover.
   always @(negedge clk) begin
      if (frame_done) begin
         fd_cnt++;
         check("frame_done_after_last", {acc_prev, 8'(got.size() % NWIN)}, {1'b1, 8'd0});
      end
      acc_prev = win_valid && win_ready && !rst;
      if (acc_prev) got.push_back(window_out);
   end

   task automatic clear_log();
      got.delete();
      fd_cnt = 0;
   endtask

   task automatic send_pix(input int v, input bit gaps);
      int n;
      n = 0;
      if (gaps && $urandom_range(0, 1) == 1) begin
         pix_valid = 1'b0;
         @(posedge clk); #1;
      end
      pix_in    = TB'(v);
      pix_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!pix_ready && n < 500);
      check("pix_ready_wait", pix_ready, 1);
      @(posedge clk); #1;
      pix_valid = 1'b0;
   endtask

   task automatic send_frame(input int base, input bit gaps);
      for (int i = 0; i < W*H; i++) send_pix(base + i, gaps);
   endtask

   task automatic drain();
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic check_frames(input string name, input int nfr, input int base2);
      check({name, "_count"}, got.size(), nfr*4);
      for (int f = 0; f < nfr; f++)
         for (int i = 0; i < 4; i++)
            if (f*4 + i < got.size())
               check($sformatf("%s_f%0d_win(%0d,%0d)", name, f, tbl[i].r, tbl[i].c),
                     got[f*4 + i], pack9(tbl[i].taps, (f == 0) ? 0 : base2));
      check({name, "_frame_done_pulses"}, fd_cnt, nfr);
   endtask

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_in    = '0;
      win_ready = 1'b1;
`ifdef CONV_WINGEN_ZPAD_EN
      tbl[0].r = 0; tbl[0].c = 0; tbl[0].taps = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
      tbl[1].r = 3; tbl[1].c = 3; tbl[1].taps = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
      tbl[2] = tbl[0];
      tbl[3] = tbl[1];
`else
      tbl[0].r = 2; tbl[0].c = 2; tbl[0].taps = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      tbl[1].r = 2; tbl[1].c = 3; tbl[1].taps = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      tbl[2].r = 3; tbl[2].c = 2; tbl[2].taps = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
      tbl[3].r = 3; tbl[3].c = 3; tbl[3].taps = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset_win_valid", win_valid, 0);
      check("reset_window_out", window_out, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_pix_ready", pix_ready, 1);
      rst = 1'b0;

`ifdef CONV_WINGEN_ZPAD_EN
      clear_log();
      send_frame(0, 1'b0);
      drain();
      check("zpad_count", got.size(), 16);
      if (got.size() == 16) begin
         check("zpad_first_win", got[0], pack9(tbl[0].taps, 0));
         check("zpad_last_win", got[15], pack9(tbl[1].taps, 0));
      end
      check("zpad_frame_done_pulses", fd_cnt, 1);
`else
      // 1: plain stream, first window one cycle after pixel 10
      clear_log();
      for (int i = 0; i < W*H; i++) begin
         send_pix(i, 1'b0);
         if (i == 9) check("t1_no_win_before_px10", win_valid, 0);
         if (i == 10) begin
            check("t1_first_latency", win_valid, 1);
            check("t1_first_win", window_out, pack9(tbl[0].taps, 0));
         end
      end
      drain();
      check_frames("t1", 1, 0);

      // 2: stall the first window for 5 cycles
      clear_log();
      fork
         send_frame(0, 1'b0);
         begin
            int n;
            n = 0;
            while (!win_valid && n < 200) begin
               @(posedge clk); #1;
               n++;
            end
            win_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("t2_hold_pix_ready", pix_ready, 0);
               check("t2_hold_valid", win_valid, 1);
               check("t2_hold_window", window_out, pack9(tbl[0].taps, 0));
            end
            @(posedge clk); #1;
            win_ready = 1'b1;
         end
      join
      drain();
      check_frames("t2", 1, 0);

      // 3: random input bubbles
      clear_log();
      send_frame(0, 1'b1);
      drain();
      check_frames("t3", 1, 0);

      // 4: two frames back-to-back
      clear_log();
      send_frame(0, 1'b0);
      send_frame(100, 1'b0);
      drain();
      check_frames("t4", 2, 100);

      // 5a: reset after pixel 6, then a full frame
      clear_log();
      for (int i = 0; i <= 6; i++) send_pix(i, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5a_valid_after_rst", win_valid, 0);
      check("t5a_frame_done_after_rst", frame_done, 0);
      send_frame(0, 1'b0);
      drain();
      check_frames("t5a", 1, 0);

      // 5b: reset while a window is held
      win_ready = 1'b0;
      clear_log();
      for (int i = 0; i <= 10; i++) send_pix(i, 1'b0);
      check("t5b_valid_before_rst", win_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5b_valid_after_rst", win_valid, 0);
      check("t5b_window_after_rst", window_out, 0);
      win_ready = 1'b1;
      clear_log();
      send_frame(0, 1'b0);
      drain();
      check_frames("t5b", 1, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
